// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared CPU package. Holds the fetch-stage defaults (ROM
//               address width, reset PC, bubble instruction), the fetch
//               action encoding and the ID/EX stage decode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    // ------------------------------------------------------------------
    // IF stage defaults
    // ------------------------------------------------------------------
    localparam int          C_ADDR_WIDTH = 13;
    localparam logic [31:0] C_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] C_NOP_INSTR  = 32'h0000_0013;   // addi x0,x0,0

    // One action per cycle, listed from highest to lowest priority.
    typedef enum logic [1:0] {
        ACT_RESET    = 2'd0,
        ACT_REDIRECT = 2'd1,
        ACT_STALL    = 2'd2,
        ACT_ADVANCE  = 2'd3
    } fetch_act_e;

    // ------------------------------------------------------------------
    // ID/EX stage constants (RV32I major opcodes)
    // ------------------------------------------------------------------
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with load, hold and bubble controls.
//               Priority: reset, bubble, load, hold.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_load             : capture {i_pc, i_pc4, i_instr} as a valid entry
//   i_bubble           : replace entry with NOP_INSTR / valid=0, pc fields held
//   o_pc/o_pc4/o_instr : registered IF/ID fields
//   o_valid            : entry is a real instruction
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc4,
    input  logic [31:0] i_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic [31:0] o_instr,
    output logic        o_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_pc4;
    logic [31:0] r_instr;
    logic        r_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc    <= 32'd0;
            r_pc4   <= 32'd0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            // pc/pc4 deliberately kept: a bubble carries no address of its own
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_pc4   <= i_pc4;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Owns the PC, drives the ROM address
//               combinationally and captures the ROM word into IF/ID in the
//               same cycle. Handles redirect, stall, misaligned-target pulse
//               and a sticky out-of-ROM fetch fault.
//   i_clk, i_rst               : clock, synchronous active-high reset
//   i_stall                    : hold PC and IF/ID
//   i_redirect, i_redirect_pc  : taken branch/jump from EX
//   o_imem_addr, i_imem_data   : instruction ROM interface
//   o_id_pc/pc4/instr/valid    : IF/ID register outputs
//   o_misalign                 : one-cycle pulse, redirect target bits[1:0]!=0
//   o_fetch_fault              : sticky, fetch beyond the ROM range
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          ADDR_WIDTH = C_ADDR_WIDTH,
    parameter logic [31:0] RESET_PC   = C_RESET_PC,
    parameter logic [31:0] NOP_INSTR  = C_NOP_INSTR
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_redirect,
    input  logic [31:0]           i_redirect_pc,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic [31:0]           i_imem_data,
    output logic [31:0]           o_id_pc,
    output logic [31:0]           o_id_pc4,
    output logic [31:0]           o_id_instr,
    output logic                  o_id_valid,
    output logic                  o_misalign,
    output logic                  o_fetch_fault
);

    logic [31:0] r_pc;
    logic        r_misalign;
    logic        r_fault;
    logic [31:0] w_pc4;
    logic        w_out_of_range;
    fetch_act_e  w_act;

    assign w_pc4       = r_pc + 32'd4;
    assign o_imem_addr = r_pc[ADDR_WIDTH-1:0];

    // Any set bit above the ROM window means the fetch misses the ROM.
    generate
        if (ADDR_WIDTH < 32) begin : g_range_check
            assign w_out_of_range = |r_pc[31:ADDR_WIDTH];
        end else begin : g_full_range
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    always_comb begin
        w_act = ACT_ADVANCE;
        if (i_rst) begin
            w_act = ACT_RESET;
        end else if (i_redirect) begin
            w_act = ACT_REDIRECT;   // wins over stall: stalled ID op is wrong-path
        end else if (i_stall) begin
            w_act = ACT_STALL;
        end
    end

    always_ff @(posedge i_clk) begin
        case (w_act)
            ACT_RESET: begin
                r_pc       <= RESET_PC;
                r_misalign <= 1'b0;
                r_fault    <= 1'b0;
            end
            ACT_REDIRECT: begin
                r_pc       <= {i_redirect_pc[31:2], 2'b00};
                r_misalign <= |i_redirect_pc[1:0];
            end
            ACT_STALL: begin
                r_misalign <= 1'b0;
            end
            default: begin
                r_pc       <= w_pc4;
                r_misalign <= 1'b0;
                if (w_out_of_range) begin
                    r_fault <= 1'b1;
                end
            end
        endcase
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   ((w_act == ACT_ADVANCE) && !w_out_of_range),
        .i_bubble ((w_act == ACT_REDIRECT) || ((w_act == ACT_ADVANCE) && w_out_of_range)),
        .i_pc     (r_pc),
        .i_pc4    (w_pc4),
        .i_instr  (i_imem_data),
        .o_pc     (o_id_pc),
        .o_pc4    (o_id_pc4),
        .o_instr  (o_id_instr),
        .o_valid  (o_id_valid)
    );

    assign o_misalign    = r_misalign;
    assign o_fetch_fault = r_fault;

endmodule : fetch_stage
`default_nettype wire
